// File: rtl/an_rx_tone_uart_if.sv
// rtl/an_rx_tone_uart_if.sv - level-window input and decoded-byte output bundle for the tone UART receiver
interface an_rx_tone_uart_if;
  logic [11:0] LVs_i;
  logic        DONE_i;
  logic        TONE_o;
  logic [7:0]  DATs_o;
  logic        VALID_o;
  logic        FERR_o;
  logic        BUSY_o;

  // Upstream side: the level detector feeding windows and whoever consumes bytes
  modport master (
    output LVs_i, DONE_i,
    input  TONE_o, DATs_o, VALID_o, FERR_o, BUSY_o
  );

  // Receiver side
  modport slave (
    input  LVs_i, DONE_i,
    output TONE_o, DATs_o, VALID_o, FERR_o, BUSY_o
  );
endinterface

// File: rtl/an_rx_tone_uart.sv
// rtl/an_rx_tone_uart.sv - hysteresis tone detector with debounce feeding a window-counted UART frame decoder
module an_rx_tone_uart #(
  parameter logic [11:0] C_TH_ON  = 12'd800,
  parameter logic [11:0] C_TH_OFF = 12'd400,
  parameter int unsigned C_DEB    = 2,
  parameter int unsigned C_SPB    = 4
) (
  input logic               CK_i,
  input logic               SRST_i,
  an_rx_tone_uart_if.slave  bus
);

  localparam logic [3:0] C_DEB_W  = 4'(C_DEB);
  localparam logic [7:0] C_SPB_W  = 8'(C_SPB);
  localparam logic [7:0] C_HALF_W = 8'(C_SPB / 2);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_START    = 3'd1,
    S_DATA     = 3'd2,
    S_STOP     = 3'd3,
    S_WAIT_OFF = 3'd4
  } state_t;

  // Tone detector state
  logic       tone_q;
  logic [3:0] deb_q;
  logic [3:0] deb_inc;
  logic       qual;

  // Frame decoder state
  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d, cnt_inc;
  logic [2:0] idx_q, idx_d;
  logic [7:0] shreg_q, shreg_d;
  logic [7:0] dat_q, dat_d;
  logic       valid_q, valid_d;
  logic       ferr_q, ferr_d;
  logic       busy;

  // Hysteresis qualification: the threshold that matters depends on the current tone state
  always_comb begin
    qual    = tone_q ? (bus.LVs_i < C_TH_OFF) : (bus.LVs_i >= C_TH_ON);
    deb_inc = (deb_q == 4'hF) ? deb_q : deb_q + 4'd1;
    cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
  end

  // Debounce: toggle the tone only after C_DEB consecutive qualifying windows
  always_ff @(posedge CK_i) begin
    if (SRST_i) begin
      tone_q <= 1'b0;
      deb_q  <= 4'd0;
    end else if (bus.DONE_i) begin
      if (qual) begin
        if (deb_inc >= C_DEB_W) begin
          tone_q <= ~tone_q;
          deb_q  <= 4'd0;
        end else begin
          deb_q <= deb_inc;
        end
      end else begin
        deb_q <= 4'd0;
      end
    end
  end

  // Frame decoder state register; strobes fall back to zero on every non-decision cycle
  always_ff @(posedge CK_i) begin
    if (SRST_i) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      idx_q   <= 3'd0;
      shreg_q <= 8'h00;
      dat_q   <= 8'h00;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      dat_q   <= dat_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  // Next-state logic; decisions use tone_q as registered before this window, one window late
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    dat_d   = dat_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    if (bus.DONE_i) begin
      case (state_q)
        S_IDLE: begin
          if (tone_q) begin
            state_d = S_START;
            cnt_d   = 8'd1;
          end
        end
        S_START: begin
          cnt_d = cnt_inc;
          // Mid-start-bit check rejects short tone bursts silently
          if (cnt_inc >= C_HALF_W) begin
            cnt_d = 8'd0;
            if (tone_q) begin
              state_d = S_DATA;
              idx_d   = 3'd0;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
        S_DATA: begin
          cnt_d = cnt_inc;
          if (cnt_inc >= C_SPB_W) begin
            cnt_d          = 8'd0;
            shreg_d[idx_q] = tone_q;
            if (idx_q == 3'd7) begin
              state_d = S_STOP;
            end else begin
              idx_d = idx_q + 3'd1;
            end
          end
        end
        S_STOP: begin
          cnt_d = cnt_inc;
          if (cnt_inc >= C_SPB_W) begin
            cnt_d = 8'd0;
            if (!tone_q) begin
              dat_d   = shreg_q;
              valid_d = 1'b1;
              state_d = S_IDLE;
            end else begin
              ferr_d  = 1'b1;
              state_d = S_WAIT_OFF;
            end
          end
        end
        S_WAIT_OFF: begin
          // A stuck-on tone must drop before a new frame can start
          if (!tone_q) begin
            state_d = S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = 8'd0;
        end
      endcase
    end
  end

  // Output decode
  always_comb begin
    busy = (state_q != S_IDLE);
  end

  assign bus.TONE_o  = tone_q;
  assign bus.DATs_o  = dat_q;
  assign bus.VALID_o = valid_q;
  assign bus.FERR_o  = ferr_q;
  assign bus.BUSY_o  = busy;

endmodule

// File: tb/tb_an_rx_tone_uart.sv
// tb/tb_an_rx_tone_uart.sv - directed-vector bench for the tone UART receiver
module tb_an_rx_tone_uart;

  localparam logic [11:0] LV_ON  = 12'd1000;
  localparam logic [11:0] LV_OFF = 12'd100;

  logic clk = 1'b0;
  logic srst;

  always #5 clk = ~clk;

  an_rx_tone_uart_if bus ();

  an_rx_tone_uart dut (
    .CK_i   (clk),
    .SRST_i (srst),
    .bus    (bus)
  );

  int n_total = 0;
  int n_bad   = 0;

  // Free-running event counters; sections compare deltas against a snapshot
  int vcnt = 0, fcnt = 0, nboth = 0, tone_hi = 0, tone_lo = 0, busy_hi = 0;
  int v_b, f_b, th_b, tl_b, bh_b;
  int  wcnt;
  bit  use_gaps;

  // Sample outputs on the falling edge, away from the active edge
  always @(negedge clk) begin
    if (bus.VALID_o) vcnt++;
    if (bus.FERR_o) fcnt++;
    if (bus.VALID_o && bus.FERR_o) nboth++;
    if (bus.TONE_o) tone_hi++;
    else tone_lo++;
    if (bus.BUSY_o) busy_hi++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic snap();
    v_b = vcnt; f_b = fcnt; th_b = tone_hi; tl_b = tone_lo; bh_b = busy_hi;
  endtask

  task automatic win(input logic [11:0] lvl);
    int gap;
    gap = use_gaps ? (wcnt % 8) : 0;
    wcnt++;
    bus.LVs_i  = lvl;
    bus.DONE_i = 1'b1;
    @(negedge clk);
    bus.DONE_i = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic wins(input logic [11:0] lvl, input int n);
    repeat (n) win(lvl);
  endtask

  task automatic send_bits(input logic [7:0] d);
    wins(LV_ON, 4);
    for (int i = 0; i < 8; i++) wins(d[i] ? LV_ON : LV_OFF, 4);
  endtask

  initial begin
    srst       = 1'b1;
    bus.LVs_i  = 12'd0;
    bus.DONE_i = 1'b0;
    use_gaps   = 1'b0;
    wcnt       = 0;
    repeat (3) @(negedge clk);
    srst = 1'b0;
    @(negedge clk);

    chk("rst_tone",  32'(bus.TONE_o),  32'd0);
    chk("rst_dat",   32'(bus.DATs_o),  32'h00);
    chk("rst_valid", 32'(bus.VALID_o), 32'd0);
    chk("rst_ferr",  32'(bus.FERR_o),  32'd0);
    chk("rst_busy",  32'(bus.BUSY_o),  32'd0);

    // Single on-window glitch never reaches the debounced tone
    snap();
    wins(LV_OFF, 4);
    win(LV_ON);
    wins(LV_OFF, 6);
    chk("glitch_tone", 32'(tone_hi - th_b), 32'd0);
    chk("glitch_busy", 32'(busy_hi - bh_b), 32'd0);

    // Hysteresis: 600 sits between thresholds, 300 is below the off threshold
    win(LV_ON);
    chk("hys_deb1", 32'(bus.TONE_o), 32'd0);
    win(LV_ON);
    chk("hys_on", 32'(bus.TONE_o), 32'd1);
    snap();
    wins(12'd600, 10);
    chk("hys_mid_low", 32'(tone_lo - tl_b), 32'd0);
    win(12'd300);
    chk("hys_off1", 32'(bus.TONE_o), 32'd1);
    win(12'd300);
    chk("hys_off2", 32'(bus.TONE_o), 32'd0);

    srst = 1'b1;
    @(negedge clk);
    srst = 1'b0;
    wins(LV_OFF, 2);

    // Clean byte 0xA5
    snap();
    wins(LV_OFF, 4);
    send_bits(8'hA5);
    wins(LV_OFF, 4);
    wins(LV_OFF, 6);
    chk("a5_valid", 32'(vcnt - v_b), 32'd1);
    chk("a5_ferr",  32'(fcnt - f_b), 32'd0);
    chk("a5_dat",   32'(bus.DATs_o), 32'hA5);
    chk("a5_busy",  32'(bus.BUSY_o), 32'd0);

    // 0x3C with a stuck-on stop bit
    snap();
    wins(LV_OFF, 4);
    send_bits(8'h3C);
    wins(LV_ON, 20);
    chk("fe_busy_stuck", 32'(bus.BUSY_o), 32'd1);
    chk("fe_ferr_early", 32'(fcnt - f_b), 32'd1);
    wins(LV_OFF, 10);
    chk("fe_ferr",  32'(fcnt - f_b), 32'd1);
    chk("fe_valid", 32'(vcnt - v_b), 32'd0);
    chk("fe_dat",   32'(bus.DATs_o), 32'hA5);
    chk("fe_busy",  32'(bus.BUSY_o), 32'd0);

    snap();
    wins(LV_OFF, 4);
    send_bits(8'h5A);
    wins(LV_OFF, 10);
    chk("5a_valid", 32'(vcnt - v_b), 32'd1);
    chk("5a_dat",   32'(bus.DATs_o), 32'h5A);

    // Reset one window into data bit 4 of 0x0F; the rest of that frame is all off
    snap();
    wins(LV_OFF, 4);
    wins(LV_ON, 4);
    wins(LV_ON, 16);
    win(LV_OFF);
    chk("rm_busy_pre", 32'(bus.BUSY_o), 32'd1);
    chk("rm_tone_pre", 32'(bus.TONE_o), 32'd1);
    srst = 1'b1;
    @(negedge clk);
    srst = 1'b0;
    chk("rm_tone",  32'(bus.TONE_o),  32'd0);
    chk("rm_dat",   32'(bus.DATs_o),  32'h00);
    chk("rm_valid", 32'(bus.VALID_o), 32'd0);
    chk("rm_ferr",  32'(bus.FERR_o),  32'd0);
    chk("rm_busy",  32'(bus.BUSY_o),  32'd0);
    wins(LV_OFF, 25);
    chk("rm_valid_cnt", 32'(vcnt - v_b), 32'd0);
    chk("rm_ferr_cnt",  32'(fcnt - f_b), 32'd0);

    snap();
    wins(LV_OFF, 4);
    send_bits(8'hFF);
    wins(LV_OFF, 10);
    chk("ff_valid", 32'(vcnt - v_b), 32'd1);
    chk("ff_dat",   32'(bus.DATs_o), 32'hFF);

    // 0x81 with 0..7 idle clocks between windows
    snap();
    use_gaps = 1'b1;
    wcnt     = 0;
    wins(LV_OFF, 4);
    send_bits(8'h81);
    wins(LV_OFF, 10);
    use_gaps = 1'b0;
    chk("gap_valid", 32'(vcnt - v_b), 32'd1);
    chk("gap_ferr",  32'(fcnt - f_b), 32'd0);
    chk("gap_dat",   32'(bus.DATs_o), 32'h81);

    chk("no_overlap", 32'(nboth), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
